// File: rtl/mem_seq_pkg.sv
// ----------------------------------------------------------------------------
// mem_seq_pkg
// Shared definitions for the memory sequencer slice.
//   - FSM state codes (kept as plain localparams for older tool flows)
//   - d_size codes and the default latency / write-hold cycle counts
//   - req_t: the request fields latched at grant time
//   - isSubWord(): true for byte/half sizes, which need read-modify-write
// ----------------------------------------------------------------------------
package mem_seq_pkg;

    localparam int unsigned DEFAULT_READ_LAT   = 2;
    localparam int unsigned DEFAULT_WRITE_HOLD = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_WAIT = 3'd1;
    localparam logic [2:0] ST_MERGE   = 3'd2;
    localparam logic [2:0] ST_WR_HOLD = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [15:0] wdata;
    } req_t;

    function automatic logic isSubWord(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// ----------------------------------------------------------------------------
// mem_lane_merge
// Combinational lane merge for byte/half stores.
//   i_old    : word previously read from memory
//   i_wdata  : right-justified store data (only the low 16 bits can matter)
//   i_size   : store size code (word and code 3 leave i_old untouched)
//   i_lane   : addr[1:0] of the store
//   o_merged : i_old with the selected byte/half replaced
// ----------------------------------------------------------------------------
module mem_lane_merge
    import mem_seq_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged
);

    // Start from the old word so every unselected lane is preserved, then
    // overwrite the addressed lane. Half stores ignore lane bit 0.
    always_comb begin
        o_merged = i_old;
        case (i_size)
            SZ_BYTE: o_merged[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_old;
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// ----------------------------------------------------------------------------
// mem_sequencer
// Arbitrates a fetch port and a data port onto one single-ported memory.
// Data requests win over fetch; the port served last is masked for the one
// IDLE cycle that follows its ack so the other port gets a turn.
//   clk, rst          : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request; if_ack pulse with if_rdata
//   d_req/d_we/d_size : data request (load/store, word/byte/half)
//   d_addr/d_wdata    : data address and right-justified store data
//   d_ack/d_rdata     : data completion pulse and loaded word
//   mem_addr/mem_we   : word-aligned memory address and write enable
//   mem_wdata         : memory write data
//   mem_rdata         : memory read data (sampled after READ_LAT cycles)
//   busy              : high whenever the sequencer is not IDLE
// ----------------------------------------------------------------------------
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned READ_LAT   = DEFAULT_READ_LAT,
    parameter int unsigned WRITE_HOLD = DEFAULT_WRITE_HOLD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] READ_CNT_INIT  = 4'(READ_LAT - 1);
    localparam logic [3:0] WRITE_CNT_INIT = 4'(WRITE_HOLD - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    req_t        r_req;
    logic [31:0] r_rdWord;
    logic [31:0] r_memWdata;
    logic [31:0] r_ifRdata;
    logic [31:0] r_dRdata;
    logic        r_maskValid;
    logic        r_maskPort;

    logic        w_dEligible;
    logic        w_ifEligible;
    logic [31:0] w_merged;

    // A port is eligible when it requests and was not the one just served.
    assign w_dEligible  = d_req  && !(r_maskValid && (r_maskPort == PORT_D));
    assign w_ifEligible = if_req && !(r_maskValid && (r_maskPort == PORT_IF));

    mem_lane_merge u_laneMerge (
        .i_old    (r_rdWord),
        .i_wdata  (r_req.wdata),
        .i_size   (r_req.size),
        .i_lane   (r_req.addr[1:0]),
        .o_merged (w_merged)
    );

    // Main sequencer. The counter is loaded with (cycles - 1) on entry to
    // RD_WAIT / WR_HOLD and the state moves on when it reaches zero. Read
    // data is captured on the edge that leaves the last RD_WAIT cycle; for a
    // sub-word store it goes to r_rdWord so MERGE can build the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rdWord    <= '0;
            r_memWdata  <= '0;
            r_ifRdata   <= '0;
            r_dRdata    <= '0;
            r_maskValid <= 1'b0;
            r_maskPort  <= PORT_IF;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_maskValid <= 1'b0;
                    if (w_dEligible) begin
                        r_req.port  <= PORT_D;
                        r_req.we    <= d_we;
                        r_req.size  <= d_size;
                        r_req.addr  <= d_addr;
                        r_req.wdata <= d_wdata[15:0];
                        if (d_we && !isSubWord(d_size)) begin
                            r_memWdata <= d_wdata;
                            r_cnt      <= WRITE_CNT_INIT;
                            r_state    <= ST_WR_HOLD;
                        end else begin
                            r_cnt   <= READ_CNT_INIT;
                            r_state <= ST_RD_WAIT;
                        end
                    end else if (w_ifEligible) begin
                        r_req.port  <= PORT_IF;
                        r_req.we    <= 1'b0;
                        r_req.size  <= SZ_WORD;
                        r_req.addr  <= if_addr;
                        r_req.wdata <= '0;
                        r_cnt       <= READ_CNT_INIT;
                        r_state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_req.we) begin
                            r_rdWord <= mem_rdata;
                            r_state  <= ST_MERGE;
                        end else begin
                            if (r_req.port == PORT_IF) begin
                                r_ifRdata <= mem_rdata;
                            end else begin
                                r_dRdata <= mem_rdata;
                            end
                            r_state <= ST_ACK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_MERGE: begin
                    r_memWdata <= w_merged;
                    r_cnt      <= WRITE_CNT_INIT;
                    r_state    <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_maskValid <= 1'b1;
                    r_maskPort  <= r_req.port;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded straight from registered state, so reset clears
    // the write enable and both acks on the very edge it is sampled.
    assign mem_addr  = {r_req.addr[31:2], 2'b00};
    assign mem_we    = (r_state == ST_WR_HOLD);
    assign mem_wdata = r_memWdata;
    assign if_ack    = (r_state == ST_ACK) && (r_req.port == PORT_IF);
    assign d_ack     = (r_state == ST_ACK) && (r_req.port == PORT_D);
    assign if_rdata  = r_ifRdata;
    assign d_rdata   = r_dRdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mem_sequencer
// Self-checking bench for mem_sequencer: directed scenarios followed by
// randomized single-port transactions checked against a word-array model.
// ----------------------------------------------------------------------------
module tb_mem_sequencer;
    import mem_seq_pkg::*;

    localparam int READ_LAT   = 2;
    localparam int WRITE_HOLD = 3;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem    [0:255];
    logic [31:0] refMem [0:255];
    logic        bdWe;
    logic [7:0]  bdIdx;
    logic [31:0] bdData;
    logic [31:0] lastIf;
    logic [31:0] lastD;
    int          checkCount;
    int          errorCount;

    mem_sequencer #(
        .READ_LAT   (READ_LAT),
        .WRITE_HOLD (WRITE_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The memory the DUT talks to: combinational read, clocked write, plus a
    // backdoor port used only while the sequencer is idle to preload words.
    always @(posedge clk) begin
        if (bdWe) begin
            mem[bdIdx] <= bdData;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input int idx, input logic [31:0] val);
        bdWe      = 1'b1;
        bdIdx     = 8'(idx);
        bdData    = val;
        refMem[idx] = val;
        @(negedge clk);
        bdWe      = 1'b0;
    endtask

    // Runs one transaction on one port from an idle, unmasked sequencer and
    // checks latency, write-enable activity, returned data and memory image.
    task automatic applyStimulus(input logic isData, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          ackCycle;
        int          weCycles;
        int          weFirst;
        int          otherAcks;
        int          expCycle;
        int          idx;
        int          sh;
        logic        isStore;
        logic        isRmw;
        logic [31:0] msk;

        isStore = isData && we;
        isRmw   = isStore && (size == SZ_BYTE || size == SZ_HALF);
        idx     = int'(addr[9:2]);
        if (!isStore) expCycle = READ_LAT + 1;
        else if (isRmw) expCycle = READ_LAT + WRITE_HOLD + 2;
        else expCycle = WRITE_HOLD + 1;
        ackCycle  = 0;
        weCycles  = 0;
        weFirst   = 0;
        otherAcks = 0;

        @(negedge clk);
        if (isData) begin
            d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end

        for (int k = 1; k <= 40 && ackCycle == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput("memAddr", mem_addr, {addr[31:2], 2'b00});
                d_we    = 1'($urandom);
                d_size  = 2'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
                if_addr = $urandom;
            end
            if (mem_we) begin
                weCycles++;
                if (weFirst == 0) weFirst = k;
            end
            if (isData ? d_ack : if_ack) ackCycle = k;
            if (isData ? if_ack : d_ack) otherAcks++;
        end
        d_req  = 1'b0;
        if_req = 1'b0;

        if (isStore) begin
            if (size == SZ_BYTE) begin
                sh  = 8 * int'(addr[1:0]);
                msk = 32'h0000_00FF << sh;
                refMem[idx] = (refMem[idx] & ~msk) | ((wdata & 32'h0000_00FF) << sh);
            end else if (size == SZ_HALF) begin
                sh  = addr[1] ? 16 : 0;
                msk = 32'h0000_FFFF << sh;
                refMem[idx] = (refMem[idx] & ~msk) | ((wdata & 32'h0000_FFFF) << sh);
            end else begin
                refMem[idx] = wdata;
            end
        end else if (isData) begin
            lastD = refMem[idx];
        end else begin
            lastIf = refMem[idx];
        end

        checkOutput("ackCycle", ackCycle, expCycle);
        checkOutput("weCycles", weCycles, isStore ? WRITE_HOLD : 0);
        if (isStore) checkOutput("weFirst", weFirst, isRmw ? READ_LAT + 2 : 1);
        checkOutput("otherAck", otherAcks, 0);
        checkOutput("ifRdata", if_rdata, lastIf);
        checkOutput("dRdata", d_rdata, lastD);
        checkOutput("memWord", mem[idx], refMem[idx]);

        @(negedge clk);
        checkOutput("idleAfterAck", 32'({busy, if_ack, d_ack}), 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Test sequence: reset values, directed scenarios, reset abort, random.
    initial begin
        int dAckCycle;
        int ifAckCycle;
        int stray;

        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = SZ_WORD; d_addr = '0; d_wdata = '0;
        bdWe = 1'b0; bdIdx = '0; bdData = '0;
        lastIf = '0;
        lastD  = '0;

        @(negedge clk);
        for (int i = 0; i < 256; i++) loadWord(i, $urandom);
        loadWord(32'h100 >> 2, 32'hDEAD_BEEF);
        loadWord(32'h104 >> 2, 32'h0102_0304);
        loadWord(32'h200 >> 2, 32'h1122_3344);

        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstIfAck", 32'(if_ack), 32'd0);
        checkOutput("rstDAck", 32'(d_ack), 32'd0);
        checkOutput("rstMemWe", 32'(mem_we), 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'd0);
        checkOutput("rstMemWdata", mem_wdata, 32'd0);
        checkOutput("rstIfRdata", if_rdata, 32'd0);
        checkOutput("rstDRdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, SZ_WORD, 32'h100, 32'h0);
        checkOutput("fetchWord", if_rdata, 32'hDEAD_BEEF);

        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h104;
        if_req = 1'b1; if_addr = 32'h100;
        dAckCycle  = 0;
        ifAckCycle = 0;
        for (int k = 1; k <= 30 && ifAckCycle == 0; k++) begin
            @(negedge clk);
            if (d_ack) begin
                dAckCycle = k;
                checkOutput("dualDRdata", d_rdata, 32'h0102_0304);
                d_req = 1'b0;
            end
            if (if_ack) begin
                ifAckCycle = k;
                checkOutput("dualIfRdata", if_rdata, 32'hDEAD_BEEF);
                if_req = 1'b0;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        lastD  = 32'h0102_0304;
        lastIf = 32'hDEAD_BEEF;
        checkOutput("dualDAckCycle", dAckCycle, 3);
        checkOutput("dualIfAckCycle", ifAckCycle, 7);
        @(negedge clk);

        applyStimulus(1'b1, 1'b1, SZ_BYTE, 32'h202, 32'h0000_00AA);
        checkOutput("sbWord", mem[32'h200 >> 2], 32'h11AA_3344);
        loadWord(32'h200 >> 2, 32'h1122_3344);
        applyStimulus(1'b1, 1'b1, SZ_HALF, 32'h201, 32'h0000_BEEF);
        checkOutput("shWord", mem[32'h200 >> 2], 32'h1122_BEEF);

        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = SZ_WORD; d_addr = 32'h300; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("swWeCycle1", 32'(mem_we), 32'd1);
        @(negedge clk);
        rst   = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortMemWe", 32'(mem_we), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDAck", 32'(d_ack), 32'd0);
        checkOutput("abortMemAddr", mem_addr, 32'd0);
        checkOutput("abortDRdata", d_rdata, 32'd0);
        checkOutput("abortIfRdata", if_rdata, 32'd0);
        lastD  = '0;
        lastIf = '0;
        refMem[32'h300 >> 2] = 32'hCAFE_F00D;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (d_ack || if_ack || busy) stray++;
        end
        checkOutput("abortQuiet", stray, 0);
        applyStimulus(1'b0, 1'b0, SZ_WORD, 32'h300, 32'h0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom), 2'($urandom),
                          32'($urandom_range(0, 255)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
